// File: rtl/edge_bram_scheduler.sv
// ----------------------------------------------------------------------------
// edge_bram_scheduler
//
// Sequences the per-frame edge-map pipeline and arbitrates the single edge
// BRAM. Each frame the BRAM is cleared, then the edge detector runs, then the
// edge-widening engine runs. Only one requester owns the BRAM ports at a time.
// Between frames the read port belongs to the display path. A stage watchdog
// aborts a stuck DETECT or WIDEN stage. One pending frame request is queued.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   frame_start                 one-cycle frame request
//   busy                        high whenever the state is not IDLE
//   frame_done                  one-cycle pulse on successful completion
//   error                       sticky watchdog flag, cleared by next start
//   overrun                     one-cycle pulse when a request is dropped
//   det_start / det_done        detector handshake (level start, held done)
//   det_addr_rd/_wr, det_wdata, det_we    detector BRAM access
//   wid_start / wid_done        widener handshake (start low resets widener)
//   wid_addr_rd/_wr, wid_wdata, wid_we    widener BRAM access
//   disp_addr, disp_valid       display read address / read-port ownership
//   bram_addra, bram_dina, bram_wea       BRAM write port A
//   bram_addrb                  BRAM read port B address
// ----------------------------------------------------------------------------
module edge_bram_scheduler #(
    parameter int NUM_PIXELS     = 307200,
    parameter int TIMEOUT_CYCLES = 16000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    output logic        busy,
    output logic        frame_done,
    output logic        error,
    output logic        overrun,
    output logic        det_start,
    input  logic        det_done,
    input  logic [18:0] det_addr_rd,
    input  logic [18:0] det_addr_wr,
    input  logic [2:0]  det_wdata,
    input  logic        det_we,
    output logic        wid_start,
    input  logic        wid_done,
    input  logic [18:0] wid_addr_rd,
    input  logic [18:0] wid_addr_wr,
    input  logic [2:0]  wid_wdata,
    input  logic        wid_we,
    input  logic [18:0] disp_addr,
    output logic        disp_valid,
    output logic [18:0] bram_addra,
    output logic [2:0]  bram_dina,
    output logic        bram_wea,
    output logic [18:0] bram_addrb
);

    localparam logic [18:0] LAST_ADDR = 19'(NUM_PIXELS - 1);
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_DETECT = 3'd2,
        S_WIDEN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      state_r;
    logic [18:0] clear_addr_r;
    logic [31:0] wdog_r;
    logic        pending_r;

    // Frame sequencer: state, handshakes, watchdog, request queue and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            clear_addr_r <= 19'd0;
            wdog_r       <= 32'd0;
            pending_r    <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            error        <= 1'b0;
            overrun      <= 1'b0;
            det_start    <= 1'b0;
            wid_start    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= 1'b0;

            // A request outside IDLE (DONE included) is queued one deep; a
            // second one is dropped. IDLE/DONE transitions below may override
            // pending_r when they consume the queued request.
            if (frame_start && (state_r != S_IDLE)) begin
                if (pending_r) begin
                    overrun <= 1'b1;
                end else begin
                    pending_r <= 1'b1;
                end
            end

            case (state_r)
                S_IDLE: begin
                    if (frame_start || pending_r) begin
                        state_r      <= S_CLEAR;
                        clear_addr_r <= 19'd0;
                        error        <= 1'b0;
                        pending_r    <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clear_addr_r == LAST_ADDR) begin
                        state_r   <= S_DETECT;
                        det_start <= 1'b1;
                        wdog_r    <= 32'd0;
                    end else begin
                        clear_addr_r <= clear_addr_r + 19'd1;
                    end
                end
                S_DETECT: begin
                    // Done takes priority over a simultaneous timeout.
                    if (det_done) begin
                        state_r   <= S_WIDEN;
                        det_start <= 1'b0;
                        wid_start <= 1'b1;
                        wdog_r    <= 32'd0;
                    end else if (wdog_r == WDOG_LAST) begin
                        state_r   <= S_IDLE;
                        error     <= 1'b1;
                        det_start <= 1'b0;
                        wid_start <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        wdog_r <= wdog_r + 32'd1;
                    end
                end
                S_WIDEN: begin
                    if (wid_done) begin
                        state_r    <= S_DONE;
                        wid_start  <= 1'b0;
                        frame_done <= 1'b1;
                    end else if (wdog_r == WDOG_LAST) begin
                        state_r   <= S_IDLE;
                        error     <= 1'b1;
                        det_start <= 1'b0;
                        wid_start <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        wdog_r <= wdog_r + 32'd1;
                    end
                end
                S_DONE: begin
                    if (pending_r) begin
                        state_r      <= S_CLEAR;
                        clear_addr_r <= 19'd0;
                        pending_r    <= 1'b0;
                    end else begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    busy      <= 1'b0;
                    det_start <= 1'b0;
                    wid_start <= 1'b0;
                end
            endcase
        end
    end

    // BRAM port ownership mux, driven from the registered state so an async
    // reset immediately returns the ports to their idle/display settings.
    always_comb begin
        bram_addra = 19'd0;
        bram_dina  = 3'd0;
        bram_wea   = 1'b0;
        bram_addrb = 19'd0;
        disp_valid = 1'b0;
        case (state_r)
            S_IDLE: begin
                bram_addrb = disp_addr;
                disp_valid = 1'b1;
            end
            S_CLEAR: begin
                bram_addra = clear_addr_r;
                bram_wea   = 1'b1;
            end
            S_DETECT: begin
                bram_addra = det_addr_wr;
                bram_dina  = det_wdata;
                bram_wea   = det_we;
                bram_addrb = det_addr_rd;
            end
            S_WIDEN: begin
                bram_addra = wid_addr_wr;
                bram_dina  = wid_wdata;
                bram_wea   = wid_we;
                bram_addrb = wid_addr_rd;
            end
            S_DONE: begin
                bram_wea = 1'b0;
            end
            default: begin
                bram_wea = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_edge_bram_scheduler.sv
// ----------------------------------------------------------------------------
// tb_edge_bram_scheduler
//
// Directed testbench for edge_bram_scheduler with a shrunk frame (16 pixels)
// and watchdog (50 cycles). Inputs change 1 time unit after the rising edge;
// outputs are checked after they settle in the same cycle.
// ----------------------------------------------------------------------------
module tb_edge_bram_scheduler;

    localparam int NP = 16;
    localparam int TO = 50;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic        busy;
    logic        frame_done;
    logic        error;
    logic        overrun;
    logic        det_start;
    logic        det_done;
    logic [18:0] det_addr_rd;
    logic [18:0] det_addr_wr;
    logic [2:0]  det_wdata;
    logic        det_we;
    logic        wid_start;
    logic        wid_done;
    logic [18:0] wid_addr_rd;
    logic [18:0] wid_addr_wr;
    logic [2:0]  wid_wdata;
    logic        wid_we;
    logic [18:0] disp_addr;
    logic        disp_valid;
    logic [18:0] bram_addra;
    logic [2:0]  bram_dina;
    logic        bram_wea;
    logic [18:0] bram_addrb;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_cnt  = 0;

    edge_bram_scheduler #(
        .NUM_PIXELS    (NP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .busy       (busy),
        .frame_done (frame_done),
        .error      (error),
        .overrun    (overrun),
        .det_start  (det_start),
        .det_done   (det_done),
        .det_addr_rd(det_addr_rd),
        .det_addr_wr(det_addr_wr),
        .det_wdata  (det_wdata),
        .det_we     (det_we),
        .wid_start  (wid_start),
        .wid_done   (wid_done),
        .wid_addr_rd(wid_addr_rd),
        .wid_addr_wr(wid_addr_wr),
        .wid_wdata  (wid_wdata),
        .wid_we     (wid_we),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_wea   (bram_wea),
        .bram_addrb (bram_addrb)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts frame_done pulses seen mid-cycle.
    always @(negedge clk) begin
        if (rst_n && frame_done) fd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first CLEAR cycle.
    task automatic start_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // From the first CLEAR cycle to the first DETECT cycle.
    task automatic finish_clear();
        repeat (NP) step();
    endtask

    // From DETECT to the first WIDEN cycle.
    task automatic pass_detect();
        repeat (3) step();
        det_done = 1'b1;
        step();
        det_done = 1'b0;
    endtask

    initial begin
        int fd_base;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        det_done    = 1'b0;
        det_addr_rd = 19'd0;
        det_addr_wr = 19'd0;
        det_wdata   = 3'd0;
        det_we      = 1'b0;
        wid_done    = 1'b0;
        wid_addr_rd = 19'd0;
        wid_addr_wr = 19'd0;
        wid_wdata   = 3'd0;
        wid_we      = 1'b0;
        disp_addr   = 19'd1234;
        #12;
        // Reset values and idle display ownership.
        check_eq("rst_busy",      32'(busy),       32'd0);
        check_eq("rst_frame_done",32'(frame_done), 32'd0);
        check_eq("rst_error",     32'(error),      32'd0);
        check_eq("rst_overrun",   32'(overrun),    32'd0);
        check_eq("rst_det_start", 32'(det_start),  32'd0);
        check_eq("rst_wid_start", 32'(wid_start),  32'd0);
        check_eq("rst_wea",       32'(bram_wea),   32'd0);
        check_eq("rst_addra",     32'(bram_addra), 32'd0);
        check_eq("rst_dina",      32'(bram_dina),  32'd0);
        check_eq("idle_addrb",    32'(bram_addrb), 32'd1234);
        check_eq("idle_disp",     32'(disp_valid), 32'd1);
        rst_n = 1'b1;
        step();
        check_eq("idle_busy", 32'(busy), 32'd0);

        // ---- Normal frame ----
        start_frame();
        check_eq("clr_busy",  32'(busy),       32'd1);
        check_eq("clr_disp",  32'(disp_valid), 32'd0);
        check_eq("clr_addrb", 32'(bram_addrb), 32'd0);
        for (int i = 0; i < NP; i++) begin
            check_eq("clr_addra", 32'(bram_addra), 32'(i));
            check_eq("clr_wea",   32'(bram_wea),   32'd1);
            check_eq("clr_dina",  32'(bram_dina),  32'd0);
            check_eq("clr_det_start_low", 32'(det_start), 32'd0);
            step();
        end
        check_eq("det_start_rise", 32'(det_start), 32'd1);
        check_eq("det_wea_idle",   32'(bram_wea),  32'd0);
        repeat (3) step();
        det_done = 1'b1;
        step();
        det_done = 1'b0;
        check_eq("handoff_det_start", 32'(det_start), 32'd0);
        check_eq("handoff_wid_start", 32'(wid_start), 32'd1);
        wid_addr_wr = 19'd641;
        wid_wdata   = 3'd2;
        wid_we      = 1'b1;
        wid_addr_rd = 19'd77;
        det_we      = 1'b1;
        det_addr_wr = 19'd5;
        #1;
        check_eq("wid_addra", 32'(bram_addra), 32'd641);
        check_eq("wid_dina",  32'(bram_dina),  32'd2);
        check_eq("wid_wea",   32'(bram_wea),   32'd1);
        check_eq("wid_addrb", 32'(bram_addrb), 32'd77);
        wid_we   = 1'b0;
        det_we   = 1'b0;
        #1;
        check_eq("wid_wea_off", 32'(bram_wea), 32'd0);
        wid_done = 1'b1;
        step();
        wid_done = 1'b0;
        check_eq("done_pulse",     32'(frame_done), 32'd1);
        check_eq("done_wid_start", 32'(wid_start),  32'd0);
        check_eq("done_busy",      32'(busy),       32'd1);
        check_eq("done_wea",       32'(bram_wea),   32'd0);
        step();
        check_eq("done_pulse_end", 32'(frame_done), 32'd0);
        check_eq("end_busy",       32'(busy),       32'd0);
        check_eq("end_disp",       32'(disp_valid), 32'd1);
        check_eq("fd_count_1",     32'(fd_cnt),     32'd1);

        // ---- Watchdog timeout in WIDEN ----
        fd_base = fd_cnt;
        start_frame();
        finish_clear();
        pass_detect();
        repeat (TO - 1) step();
        check_eq("wd_pre_busy",  32'(busy),      32'd1);
        check_eq("wd_pre_error", 32'(error),     32'd0);
        check_eq("wd_pre_wid",   32'(wid_start), 32'd1);
        step();
        check_eq("wd_error",     32'(error),      32'd1);
        check_eq("wd_wid_start", 32'(wid_start),  32'd0);
        check_eq("wd_busy",      32'(busy),       32'd0);
        check_eq("wd_disp",      32'(disp_valid), 32'd1);
        step();
        check_eq("wd_sticky",    32'(error),      32'd1);
        check_eq("wd_no_done",   32'(fd_cnt - fd_base), 32'd0);
        start_frame();
        check_eq("wd_err_clear", 32'(error), 32'd0);

        // ---- Async reset in WIDEN drops everything, including pending ----
        finish_clear();
        pass_detect();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        wid_we      = 1'b1;
        #1;
        check_eq("pre_rst_wea", 32'(bram_wea), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_wid_start", 32'(wid_start), 32'd0);
        check_eq("arst_wea",       32'(bram_wea),  32'd0);
        check_eq("arst_busy",      32'(busy),      32'd0);
        wid_we = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        check_eq("arst_pending_lost", 32'(busy), 32'd0);

        // ---- Queued request and overrun ----
        fd_base = fd_cnt;
        start_frame();
        finish_clear();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check_eq("ovr_first_queued", 32'(overrun), 32'd0);
        pass_detect();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check_eq("ovr_pulse", 32'(overrun), 32'd1);
        step();
        check_eq("ovr_pulse_end", 32'(overrun), 32'd0);
        wid_done = 1'b1;
        step();
        wid_done = 1'b0;
        check_eq("ovr_done1", 32'(frame_done), 32'd1);
        step();
        check_eq("ovr_clear2_busy",  32'(busy),       32'd1);
        check_eq("ovr_clear2_wea",   32'(bram_wea),   32'd1);
        check_eq("ovr_clear2_addra", 32'(bram_addra), 32'd0);
        finish_clear();
        pass_detect();
        wid_done = 1'b1;
        step();
        wid_done = 1'b0;
        step();
        check_eq("ovr_idle", 32'(busy), 32'd0);
        repeat (3) step();
        check_eq("ovr_two_done", 32'(fd_cnt - fd_base), 32'd2);

        // ---- Done and timeout on the same edge: done wins ----
        fd_base = fd_cnt;
        start_frame();
        finish_clear();
        pass_detect();
        repeat (TO - 1) step();
        det_done = 1'b1;
        wid_done = 1'b1;
        step();
        det_done = 1'b0;
        wid_done = 1'b0;
        check_eq("tie_done",  32'(frame_done), 32'd1);
        check_eq("tie_error", 32'(error),      32'd0);
        step();
        check_eq("tie_idle",  32'(busy),       32'd0);
        check_eq("tie_count", 32'(fd_cnt - fd_base), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
